turn_arbiter: RTL
=================

# turn_arbiter

Turn-based arbiter that shares the single-port 16x16 board memory between two move requesters (player A and player B) that each present a 4-bit (x, y) coordinate. It clears the board after reset or on a new game, enforces alternating turns, and checks each requested cell for occupancy before writing it. Accepted moves are forwarded as one-cycle (x, y) pulses to downstream game logic. A turn timeout forfeits the move of a player who stalls.

## Interface
- TIMEOUT_CYCLES, default 1000: number of idle cycles before the current turn is forfeited; 0 disables the timeout.
- GRID_CELLS, default 256: number of board cells; the clear sweep and full-board detection both use it.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- new_game  in  1  synchronous clear request, single-cycle
- req_a / req_b  in  1  move request, level; held until ack or nack
- xa, ya / xb, yb  in  4 each  requested coordinate; stable while req is high
- mem_rd_data  in  2  cell contents, valid one cycle after mem_addr
- mem_addr  out  8  {y, x}, registered
- mem_we  out  1  write enable
- mem_wr_data  out  2  cell value: 00 empty, 01 A, 10 B
- ack_a / ack_b, nack_a / nack_b  out  1 each  single-cycle response pulses
- turn  out  1  0 = A to move, 1 = B to move
- move_valid  out  1  single-cycle pulse per accepted move
- x_out, y_out  out  4 each  accepted coordinate, nonzero only while move_valid is high
- skip  out  1  single-cycle pulse when the timeout forfeits a turn
- busy  out  1  high in CLEAR
- game_over  out  1  high in OVER

## Operation
- Cell encoding: 00 empty, 01 A, 10 B. The code 11 never occurs and counts as occupied.
- CLEAR: mem_addr steps from 0 to GRID_CELLS-1, one address per cycle, with mem_we=1 and mem_wr_data=00. After the last address the FSM goes to IDLE, with turn=0 and move_count=0.
- IDLE: only the req of the current turn is sampled; the other player's req is ignored with no response. On acceptance the FSM latches x and y, loads mem_addr={y,x}, and goes to READ.
- READ: the memory samples the address. Next state is CHECK.
- CHECK: if mem_rd_data==00 the next state is WRITE, otherwise REJECT.
- WRITE: asserts mem_we, sets mem_wr_data to the player code, pulses the current player's ack, and pulses move_valid with x_out/y_out. turn toggles and move_count increments. Next state is DONE.
- REJECT: pulses the current player's nack. turn is unchanged. Next state is DONE.
- DONE: requests are ignored for this one cycle. If move_count==GRID_CELLS the next state is OVER, otherwise IDLE.
- OVER: game_over=1 and all requests are ignored until new_game or reset.
- Timeout: the counter runs only in IDLE and clears on acceptance, on any turn change, and on leaving IDLE. When it reaches TIMEOUT_CYCLES-1 with no current-turn req, skip pulses, turn toggles, and the counter clears.
- move_count is 9 bits wide and saturates at GRID_CELLS.

## Timing
- Reset values: state=CLEAR, mem_addr=0, turn=0, counters=0, busy=1, mem_we=1 (the clear sweep starts immediately). All other outputs are 0.
- Request accepted in cycle T:
  - READ at T+1, CHECK at T+2.
  - ack or nack at T+3, together with mem_we and move_valid.
  - DONE at T+4, IDLE at T+5.
- The requester deasserts req no later than T+4.
- Clear sweep: GRID_CELLS cycles, then IDLE.
- Simultaneous events:
  - Current-turn req and timeout expiry in the same cycle: the req wins.
  - Both req_a and req_b high: only the current turn's request is served.
- new_game in any state: the next state is CLEAR and any in-flight move is aborted with no ack or nack. If already in CLEAR, the sweep restarts at address 0.
- Reset mid-operation: immediate return to CLEAR, sweep restarts at address 0.

## Structure
- board_pkg holds:
  - the cell_t enum (EMPTY, PLAYER_A, PLAYER_B);
  - the arb_state_t enum (CLEAR, IDLE, READ, CHECK, WRITE, REJECT, DONE, OVER);
  - the constants GRID_DIM=16 and GRID_CELLS=256.
- turn_timer is a sub-module: a TIMEOUT_CYCLES counter with a clear input and an expire output. turn_arbiter instantiates it.

## Test plan
- Reset, then hold all inputs low: busy=1 for 256 cycles with mem_addr running 0..255 and mem_we=1. Then IDLE with turn=0.
- A requests (3,5), board empty: mem_addr=0x53 at T+1; at T+3 ack_a=1, mem_we=1, mem_wr_data=01, move_valid=1, x_out=3, y_out=5; turn=1 afterwards.
- B requests (3,5) after that move: nack_b at T+3, mem_we=0, turn stays 1. A request from A during B's turn gets no response.
- TIMEOUT_CYCLES=8, no requests: skip pulses after 8 idle cycles and turn toggles. Raising the current-turn req on the expiry cycle gives acceptance and no skip.
- GRID_CELLS=4 build: four accepted moves set game_over=1. Further requests get no ack. new_game returns the FSM to CLEAR.
- new_game asserted at T+2 of a move: no ack, the sweep restarts at address 0, and turn=0 after the clear.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board encodings and arbiter state names for the turn-based move path.
package board_pkg;
  localparam int GRID_DIM   = 16;
  localparam int GRID_CELLS = 256;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    PLAYER_A = 2'b01,
    PLAYER_B = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    CLEAR, IDLE, READ, CHECK, WRITE, REJECT, DONE, OVER
  } arb_state_t;
endpackage

// File: rtl/turn_timer.sv
// Idle-turn counter: expire_o is high on the cycle the count reaches TIMEOUT_CYCLES-1.
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q;

  // A zero timeout holds the counter and never expires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            cnt_q <= '0;
    else if (clr_i || TIMEOUT_CYCLES == 0) cnt_q <= '0;
    else                                  cnt_q <= cnt_q + CW'(1);
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);
endmodule

// File: rtl/turn_arbiter.sv
// Two-player move arbiter over the single-port board memory: clear sweep,
// alternating turns, occupancy check, move forwarding and idle-turn forfeit.
module turn_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GRID_CELLS     = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] xa,
  input  logic [3:0] ya,
  input  logic [3:0] xb,
  input  logic [3:0] yb,
  input  logic [1:0] mem_rd_data,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wr_data,
  output logic       ack_a,
  output logic       ack_b,
  output logic       nack_a,
  output logic       nack_b,
  output logic       turn,
  output logic       move_valid,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic       skip,
  output logic       busy,
  output logic       game_over
);
  import board_pkg::*;

  localparam logic [7:0] LAST_ADDR = 8'(GRID_CELLS - 1);
  localparam logic [8:0] FULL      = 9'(GRID_CELLS);

  arb_state_t state_q;
  cell_t      wr_data_q;
  logic [7:0] addr_q;
  logic [8:0] moves_q;
  logic [3:0] x_q, y_q, xo_q, yo_q;
  logic       we_q, turn_q, ack_a_q, ack_b_q, nack_a_q, nack_b_q, mv_q, skip_q;

  logic       cur_req, accept, expire, fire, tmr_clr;
  logic [3:0] cur_x, cur_y;

  assign cur_req = turn_q ? req_b : req_a;
  assign cur_x   = turn_q ? xb : xa;
  assign cur_y   = turn_q ? yb : ya;
  assign accept  = (state_q == IDLE) && cur_req;
  // A pending current-turn request always beats an expiring timer.
  assign fire    = (state_q == IDLE) && !cur_req && expire;
  assign tmr_clr = (state_q != IDLE) || accept || fire;

  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (tmr_clr),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      addr_q    <= '0;
      we_q      <= 1'b1;
      wr_data_q <= EMPTY;
      turn_q    <= 1'b0;
      moves_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      xo_q      <= '0;
      yo_q      <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      nack_a_q  <= 1'b0;
      nack_b_q  <= 1'b0;
      mv_q      <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      wr_data_q <= EMPTY;
      xo_q      <= '0;
      yo_q      <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      nack_a_q  <= 1'b0;
      nack_b_q  <= 1'b0;
      mv_q      <= 1'b0;
      skip_q    <= 1'b0;
      if (new_game) begin
        state_q <= CLEAR;
        addr_q  <= '0;
        we_q    <= 1'b1;
      end else begin
        case (state_q)
          CLEAR: begin
            if (addr_q == LAST_ADDR) begin
              state_q <= IDLE;
              we_q    <= 1'b0;
              turn_q  <= 1'b0;
              moves_q <= '0;
            end else begin
              addr_q <= addr_q + 8'd1;
            end
          end
          IDLE: begin
            if (accept) begin
              x_q     <= cur_x;
              y_q     <= cur_y;
              addr_q  <= {cur_y, cur_x};
              state_q <= READ;
            end else if (fire) begin
              skip_q <= 1'b1;
              turn_q <= ~turn_q;
            end
          end
          READ: state_q <= CHECK;
          // Read data for the latched cell is valid here; 11 counts as occupied.
          CHECK: begin
            if (mem_rd_data == EMPTY) begin
              state_q   <= WRITE;
              we_q      <= 1'b1;
              wr_data_q <= turn_q ? PLAYER_B : PLAYER_A;
              ack_a_q   <= ~turn_q;
              ack_b_q   <= turn_q;
              mv_q      <= 1'b1;
              xo_q      <= x_q;
              yo_q      <= y_q;
            end else begin
              state_q  <= REJECT;
              nack_a_q <= ~turn_q;
              nack_b_q <= turn_q;
            end
          end
          WRITE: begin
            we_q    <= 1'b0;
            turn_q  <= ~turn_q;
            if (moves_q != FULL) moves_q <= moves_q + 9'd1;
            state_q <= DONE;
          end
          REJECT:  state_q <= DONE;
          DONE:    state_q <= (moves_q == FULL) ? OVER : IDLE;
          OVER:    state_q <= OVER;
          default: state_q <= CLEAR;
        endcase
      end
    end
  end

  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_wr_data = wr_data_q;
  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign nack_a      = nack_a_q;
  assign nack_b      = nack_b_q;
  assign turn        = turn_q;
  assign move_valid  = mv_q;
  assign x_out       = xo_q;
  assign y_out       = yo_q;
  assign skip        = skip_q;
  assign busy        = (state_q == CLEAR);
  assign game_over   = (state_q == OVER);
endmodule
